// File: rtl/dm_dly_ctrl_pkg.sv
// Shared encodings for the DM/DQ lane delay-line step controller.
//   cmd_op_e : command opcodes carried on CMD_OP
//   state_e  : sequencer states
package dm_dly_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_RSVD = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DIR_SETUP,
      ST_MOVE,
      ST_GAP,
      ST_FINISH
   } state_e;

endpackage

// File: rtl/dm_dly_line_step_ctrl.sv
// Delay-line step sequencer for one DDR4 DM/DQ lane IOD (FAB_CLK domain).
// Turns LOAD/INC/DEC commands from training into spaced LOAD/DIRECTION/MOVE
// pulses, tracks the tap position and aborts on saturation or OUT_OF_RANGE.
// Ports:
//   FAB_CLK, RESET_N            clock, synchronous active-low reset
//   CMD_VALID/CMD_READY         command handshake
//   CMD_OP, CMD_STEPS           opcode and tap count
//   DONE, ERR, BUSY             completion pulse, error pulse, busy level
//   TAP_POS                     tracked tap position
//   DELAY_LINE_LOAD/MOVE/DIRECTION, DELAY_LINE_OUT_OF_RANGE   IOD interface
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | ready for a command
// ST_LOAD      | one-cycle LOAD pulse, tap restored to LOAD_VAL
// ST_DIR_SETUP | DIRECTION settling before the first MOVE
// ST_MOVE      | one-tap MOVE pulse, or saturation abort
// ST_GAP       | idle spacing after a MOVE, OUT_OF_RANGE watched
// ST_FINISH    | DONE (and ERR) pulse
module dm_dly_line_step_ctrl
   import dm_dly_ctrl_pkg::*;
#(
   parameter int NUM_TAPS      = 128,
   parameter int TAP_W         = 7,
   parameter int LOAD_VAL      = 1,
   parameter int DIR_SETUP_CYC = 1,
   parameter int MOVE_GAP_CYC  = 2
) (
   input  logic             FAB_CLK,
   input  logic             RESET_N,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [1:0]       CMD_OP,
   input  logic [TAP_W-1:0] CMD_STEPS,
   output logic             DONE,
   output logic             ERR,
   output logic             BUSY,
   output logic [TAP_W-1:0] TAP_POS,
   output logic             DELAY_LINE_LOAD,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   input  logic             DELAY_LINE_OUT_OF_RANGE
);

   localparam int CNT_MAX = (DIR_SETUP_CYC > MOVE_GAP_CYC) ? DIR_SETUP_CYC : MOVE_GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [TAP_W-1:0] TAP_MAX    = TAP_W'(NUM_TAPS - 1);
   localparam logic [TAP_W-1:0] TAP_LOAD   = TAP_W'(LOAD_VAL);
   localparam logic [CNT_W-1:0] SETUP_INIT = CNT_W'(DIR_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(MOVE_GAP_CYC - 1);

   state_e             state_q, state_d;
   logic [TAP_W-1:0]   tap_q, tap_d;
   logic [TAP_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               err_q, err_d;
   logic               at_limit;

   // Next step would push the tap past either end of the line.
   assign at_limit = dir_q ? (tap_q == TAP_MAX) : (tap_q == '0);

   always_ff @(posedge FAB_CLK) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         tap_q   <= TAP_LOAD;
         rem_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               rem_d = CMD_STEPS;
               err_d = 1'b0;
               case (cmd_op_e'(CMD_OP))
                  OP_LOAD: state_d = ST_LOAD;
                  OP_INC, OP_DEC: begin
                     if (CMD_STEPS == '0) begin
                        state_d = ST_FINISH;
                     end else begin
                        dir_d   = (cmd_op_e'(CMD_OP) == OP_INC);
                        cnt_d   = SETUP_INIT;
                        state_d = ST_DIR_SETUP;
                     end
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = ST_FINISH;
                  end
               endcase
            end
         end

         ST_LOAD: begin
            tap_d   = TAP_LOAD;
            state_d = ST_FINISH;
         end

         ST_DIR_SETUP: begin
            if (cnt_q == '0) state_d = ST_MOVE;
            else             cnt_d   = cnt_q - 1'b1;
         end

         ST_MOVE: begin
            if (at_limit) begin
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end else begin
               tap_d   = dir_q ? tap_q + 1'b1 : tap_q - 1'b1;
               rem_d   = rem_q - 1'b1;
               cnt_d   = GAP_INIT;
               state_d = ST_GAP;
            end
         end

         ST_GAP: begin
            if (DELAY_LINE_OUT_OF_RANGE) begin
               // IOD refused the last step: undo it in the tracked position.
               tap_d   = dir_q ? tap_q - 1'b1 : tap_q + 1'b1;
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end else if (cnt_q == '0) begin
               state_d = (rem_q != '0) ? ST_MOVE : ST_FINISH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_FINISH: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   assign CMD_READY            = (state_q == ST_IDLE);
   assign BUSY                 = (state_q != ST_IDLE);
   assign DONE                 = (state_q == ST_FINISH);
   assign ERR                  = (state_q == ST_FINISH) && err_q;
   assign DELAY_LINE_LOAD      = (state_q == ST_LOAD);
   assign DELAY_LINE_MOVE      = (state_q == ST_MOVE) && !at_limit;
   assign DELAY_LINE_DIRECTION = dir_q;
   assign TAP_POS              = tap_q;

endmodule

// File: tb/tb_dm_dly_line_step_ctrl.sv
// Bench for dm_dly_line_step_ctrl: per-cycle expected timeline computed from
// command rules, compared against the DUT every cycle, plus literal pins.
module tb_dm_dly_line_step_ctrl;
   import dm_dly_ctrl_pkg::*;

   localparam int NUM_TAPS = 128;
   localparam int TAP_W    = 7;
   localparam int LOAD_VAL = 1;
   localparam int DS       = 1;
   localparam int GAP      = 2;
   localparam int NC       = 256;

   logic             FAB_CLK = 1'b0;
   logic             RESET_N;
   logic             CMD_VALID;
   logic             CMD_READY;
   logic [1:0]       CMD_OP;
   logic [TAP_W-1:0] CMD_STEPS;
   logic             DONE, ERR, BUSY;
   logic [TAP_W-1:0] TAP_POS;
   logic             DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
   logic             DELAY_LINE_OUT_OF_RANGE;

   dm_dly_line_step_ctrl #(
      .NUM_TAPS(NUM_TAPS), .TAP_W(TAP_W), .LOAD_VAL(LOAD_VAL),
      .DIR_SETUP_CYC(DS), .MOVE_GAP_CYC(GAP)
   ) dut (
      .FAB_CLK(FAB_CLK), .RESET_N(RESET_N),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_OP(CMD_OP), .CMD_STEPS(CMD_STEPS),
      .DONE(DONE), .ERR(ERR), .BUSY(BUSY), .TAP_POS(TAP_POS),
      .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
      .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   int cyc = 0;
   always @(posedge FAB_CLK) cyc <= cyc + 1;

   // Expected value of every output for each cycle, plus the OOR drive plan.
   bit e_load[NC], e_move[NC], e_done[NC], e_err[NC];
   bit e_busy[NC], e_ready[NC], e_dir[NC], d_oor[NC];
   int e_tap[NC];

   typedef struct { int c; int id; int v; } pin_t;
   pin_t pins[$];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void fill_tap(int c, int v);
      for (int i = c; i < NC; i++) e_tap[i] = v;
   endfunction

   function automatic void model_reset(int r);
      for (int i = r + 1; i < NC; i++) begin
         e_load[i] = 0; e_move[i] = 0; e_done[i] = 0; e_err[i] = 0;
         e_busy[i] = 0; e_ready[i] = 1; e_dir[i] = 0; d_oor[i] = 0;
         e_tap[i]  = LOAD_VAL;
      end
   endfunction

   // Command accepted on the edge closing cycle a; cycle a+k is "cycle k".
   // oor_k: OUT_OF_RANGE raised in the first gap cycle after the k-th move.
   // noise: OUT_OF_RANGE held high through the whole command (must be ignored).
   function automatic void plan(int a, logic [1:0] op, int steps, int oor_k, bit noise);
      int tap, m, done_c;
      bit err, stop, up;
      tap = e_tap[a]; err = 0; stop = 0; done_c = a + 1;
      for (int i = a + 1; i < NC; i++) begin
         e_load[i] = 0; e_move[i] = 0; e_done[i] = 0; e_err[i] = 0;
         e_busy[i] = 0; e_ready[i] = 1; d_oor[i] = 0;
      end
      if (op == OP_LOAD) begin
         e_load[a+1] = 1;
         fill_tap(a + 2, LOAD_VAL);
         done_c = a + 2;
      end else if (op == OP_RSVD) begin
         err = 1;
      end else if (steps > 0) begin
         up = (op == OP_INC);
         for (int i = a + 1; i < NC; i++) e_dir[i] = up;
         m = a + 1 + DS;
         for (int k = 1; k <= steps && !stop; k++) begin
            if ((up && tap == NUM_TAPS - 1) || (!up && tap == 0)) begin
               err = 1; done_c = m + 1; stop = 1;
            end else begin
               e_move[m] = 1;
               tap = up ? tap + 1 : tap - 1;
               fill_tap(m + 1, tap);
               if (k == oor_k) begin
                  d_oor[m+1] = 1;
                  tap = up ? tap - 1 : tap + 1;
                  fill_tap(m + 2, tap);
                  err = 1; done_c = m + 2; stop = 1;
               end else begin
                  m = m + 1 + GAP;
               end
            end
         end
         if (!stop) done_c = m;
      end
      for (int i = a + 1; i <= done_c; i++) begin
         e_busy[i] = 1; e_ready[i] = 0;
         if (noise) d_oor[i] = 1;
      end
      e_done[done_c] = 1;
      e_err[done_c]  = err;
   endfunction

   function automatic int sig(int id);
      case (id)
         0: return int'(DELAY_LINE_LOAD);
         1: return int'(DELAY_LINE_MOVE);
         2: return int'(DONE);
         3: return int'(ERR);
         4: return int'(BUSY);
         5: return int'(CMD_READY);
         6: return int'(TAP_POS);
         default: return int'(DELAY_LINE_DIRECTION);
      endcase
   endfunction

   function automatic string sname(int id);
      case (id)
         0: return "load";
         1: return "move";
         2: return "done";
         3: return "err";
         4: return "busy";
         5: return "ready";
         6: return "tap_pos";
         default: return "direction";
      endcase
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL cyc=%0d %s actual=%0d required=%0d", cyc, nm, act, exp);
      end
   endtask

   always @(negedge FAB_CLK) begin
      if (cyc >= 1 && cyc < NC) begin
         chk("load",      sig(0), int'(e_load[cyc]));
         chk("move",      sig(1), int'(e_move[cyc]));
         chk("done",      sig(2), int'(e_done[cyc]));
         chk("err",       sig(3), int'(e_err[cyc]));
         chk("busy",      sig(4), int'(e_busy[cyc]));
         chk("ready",     sig(5), int'(e_ready[cyc]));
         chk("tap_pos",   sig(6), e_tap[cyc]);
         chk("direction", sig(7), int'(e_dir[cyc]));
         foreach (pins[i])
            if (pins[i].c == cyc) chk({"pin_", sname(pins[i].id)}, sig(pins[i].id), pins[i].v);
      end
   end

   task automatic pin(int c, int id, int v);
      pin_t p;
      p.c = c; p.id = id; p.v = v;
      pins.push_back(p);
   endtask

   task automatic tick();
      @(posedge FAB_CLK);
      #1;
      DELAY_LINE_OUT_OF_RANGE = d_oor[cyc];
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!e_ready[cyc] && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic send(input logic [1:0] op, input int steps, input int oor_k,
                       input bit noise, input int hold, output int a);
      a = cyc;
      CMD_VALID = 1'b1;
      CMD_OP    = op;
      CMD_STEPS = TAP_W'(steps);
      plan(a, op, steps, oor_k, noise);
      repeat (hold + 1) tick();
      CMD_VALID = 1'b0;
   endtask

   initial begin
      #(NC * 10 - 20);
      $display("FAIL watchdog: stimulus did not complete, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      RESET_N = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_STEPS = '0;
      DELAY_LINE_OUT_OF_RANGE = 1'b0;
      e_tap[0] = LOAD_VAL; e_ready[0] = 1;
      model_reset(0);
      // reset state pins
      pin(2, 5, 1); pin(2, 4, 0); pin(2, 6, 1); pin(2, 7, 0); pin(2, 2, 0);
      tick(); tick(); tick();
      RESET_N = 1'b1;
      tick();

      // LOAD, with OUT_OF_RANGE noise that must be ignored
      send(OP_LOAD, 0, 0, 1, 0, a);
      pin(a+1, 0, 1); pin(a+2, 0, 0); pin(a+2, 2, 1); pin(a+2, 3, 0); pin(a+2, 6, 1);
      wait_idle();

      // INC 3 from tap 1, CMD_VALID held high while busy
      pin(cyc+1, 7, 1); pin(cyc+2, 1, 1); pin(cyc+3, 1, 0); pin(cyc+5, 1, 1);
      pin(cyc+8, 1, 1); pin(cyc+11, 2, 1); pin(cyc+12, 6, 4);
      pin(cyc+1, 5, 0); pin(cyc+11, 5, 0); pin(cyc+12, 5, 1);
      send(OP_INC, 3, 0, 0, 11, a);
      wait_idle();

      // DEC 2 -> tap 2
      send(OP_DEC, 2, 0, 0, 0, a);
      pin(a+8, 2, 1); pin(a+9, 6, 2);
      wait_idle();

      // DEC 5 from 2: saturates at 0 on the third step
      send(OP_DEC, 5, 0, 0, 0, a);
      pin(a+2, 1, 1); pin(a+5, 1, 1); pin(a+8, 1, 0);
      pin(a+9, 2, 1); pin(a+9, 3, 1); pin(a+9, 6, 0); pin(a+10, 5, 1);
      wait_idle();

      // INC 4 from 0 with OUT_OF_RANGE after the 2nd move
      send(OP_INC, 4, 2, 0, 0, a);
      pin(a+2, 1, 1); pin(a+5, 1, 1); pin(a+6, 6, 2);
      pin(a+7, 6, 1); pin(a+7, 2, 1); pin(a+7, 3, 1); pin(a+8, 1, 0);
      wait_idle();

      // reserved op, valid held into the FINISH cycle
      send(OP_RSVD, 3, 0, 0, 1, a);
      pin(a+1, 2, 1); pin(a+1, 3, 1); pin(a+1, 0, 0); pin(a+1, 1, 0); pin(a+2, 4, 0);
      wait_idle();

      // INC with zero steps
      send(OP_INC, 0, 0, 0, 0, a);
      pin(a+1, 2, 1); pin(a+1, 3, 0); pin(a+1, 1, 0);
      wait_idle();

      // INC 3, reset asserted in cycle 6
      send(OP_INC, 3, 0, 0, 0, a);
      pin(a+6, 6, 3); pin(a+7, 6, LOAD_VAL); pin(a+7, 5, 1);
      pin(a+8, 1, 0); pin(a+11, 2, 0);
      while (cyc < a + 6) tick();
      RESET_N = 1'b0;
      model_reset(a + 6);
      tick();
      RESET_N = 1'b1;

      repeat (6) tick();
      @(negedge FAB_CLK);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
